// File: rtl/word_scan_pkg.sv
// Shared types for the word scan controller.
// FSM states, detector history encoding, count width.
package word_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FLUSH,
    S_REPORT
  } state_t;

  typedef logic [1:0] fill_t;
  typedef logic [2:0] hist_t;

  localparam fill_t FILL_FULL = 2'd3;
  localparam hist_t PAT_100   = 3'b100;
  localparam hist_t PAT_010   = 3'b010;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/moore_pat_det.sv
// Moore detector for overlapping "100" / "010".
// History holds the last three bits, oldest in bit 2.
module moore_pat_det
  import word_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic bit_in,
  output logic det100,
  output logic det010
);

  hist_t hist;
  fill_t fill;

  // Shift in enabled bits; clear forgets history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= {hist[1:0], bit_in};
      if (fill != FILL_FULL)
        fill <= fill + 2'd1;
    end
  end

  // Outputs decode the state only.
  always_comb begin
    det100 = (fill == FILL_FULL) && (hist == PAT_100);
    det010 = (fill == FILL_FULL) && (hist == PAT_010);
  end

endmodule

// File: rtl/word_scan_ctrl.sv
// Bit-serial scan controller around moore_pat_det.
// Accepts a word, shifts it MSB-first, reports hits.
module word_scan_ctrl
  import word_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear_hist,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_hit100,
  output logic             out_hit010,
  output logic             busy
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] sreg;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] count;
  logic             hit100;
  logic             hit010;
  logic             det100;
  logic             det010;
  logic             det_en;
  logic             det_clr;
  logic             cnt_en;

  moore_pat_det u_det (
    .clk    (clk),
    .rst    (rst),
    .en     (det_en),
    .clr    (det_clr),
    .bit_in (sreg[WIDTH-1]),
    .det100 (det100),
    .det010 (det010)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next state and handshake/detector controls.
  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    det_en    = 1'b0;
    det_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        det_clr  = clear_hist;
        if (in_valid) nxt = S_SHIFT;
      end
      S_SHIFT: begin
        det_en = 1'b1;
        // first cycle shows the previous word's last detection
        cnt_en = (idx != IDX_TOP);
        if (idx == '0) nxt = S_FLUSH;
      end
      S_FLUSH: begin
        cnt_en = 1'b1;
        nxt    = S_REPORT;
      end
      S_REPORT: begin
        out_valid = 1'b1;
        if (out_ready) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Shift register, bit index, count and hit flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg   <= '0;
      idx    <= '0;
      count  <= '0;
      hit100 <= 1'b0;
      hit010 <= 1'b0;
    end else begin
      if (state == S_IDLE && in_valid) begin
        sreg   <= in_data;
        idx    <= IDX_TOP;
        count  <= '0;
        hit100 <= 1'b0;
        hit010 <= 1'b0;
      end
      if (state == S_SHIFT) begin
        sreg <= sreg << 1;
        idx  <= idx - IDX_W'(1);
      end
      if (cnt_en && (det100 || det010)) begin
        if (count != '1) count <= count + CNT_W'(1);
        if (det100) hit100 <= 1'b1;
        if (det010) hit010 <= 1'b1;
      end
    end
  end

  assign out_count  = count;
  assign out_hit100 = hit100;
  assign out_hit010 = hit010;

endmodule

// File: tb/tb_word_scan_ctrl.sv
// Scoreboard bench for word_scan_ctrl.
// Reference model predicts each result record.
module tb_word_scan_ctrl;

  localparam int W = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          clear_hist = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CW-1:0] out_count;
  logic          out_hit100;
  logic          out_hit010;
  logic          busy;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          h100;
    logic          h010;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   fails = 0;
  logic [2:0] mh = '0;
  int   mf = 0;

  word_scan_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .clear_hist (clear_hist),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
    .out_hit100 (out_hit100),
    .out_hit010 (out_hit010),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] d,
                       input logic c,
                       output rec_t r);
    r = '0;
    if (c) mf = 0;
    for (int i = W - 1; i >= 0; i--) begin
      mh = {mh[1:0], d[i]};
      if (mf < 3) mf++;
      if (mf == 3 && mh == 3'b100) begin
        r.cnt++;
        r.h100 = 1'b1;
      end
      if (mf == 3 && mh == 3'b010) begin
        r.cnt++;
        r.h010 = 1'b1;
      end
    end
  endtask

  task automatic do_word(input logic [W-1:0] d,
                         input logic c,
                         input bit stall);
    rec_t e;
    rec_t snap;
    int n;
    model(d, c, e);
    q.push_back(e);
    @(negedge clk);
    chk("in_ready_pre", in_ready, 1);
    in_valid   = 1'b1;
    in_data    = d;
    clear_hist = c;
    out_ready  = !stall;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    clear_hist = 1'b0;
    in_data    = W'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("latency", n, W + 1);
    chk("busy_rep", busy, 1);
    if (stall) begin
      snap = {out_count, out_hit100, out_hit010};
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        in_valid = i[0];
        in_data  = W'($urandom);
        @(posedge clk);
        #1;
        chk("stall_valid", out_valid, 1);
        chk("stall_ready", in_ready, 0);
        chk("stall_rec", {out_count, out_hit100, out_hit010}, snap);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    chk("sb_nonempty", q.size() > 0, 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("count", out_count, e.cnt);
      chk("hit100", out_hit100, e.h100);
      chk("hit010", out_hit010, e.h010);
    end
    @(posedge clk);
    #1;
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", out_count, 0);
    chk("rst_h100", out_hit100, 0);
    chk("rst_h010", out_hit010, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    do_word(8'b1001_0010, 1'b1, 1'b0);
    do_word(8'hAA, 1'b1, 1'b0);
    do_word(8'h00, 1'b1, 1'b0);
    do_word(8'hFF, 1'b1, 1'b0);
    do_word(8'h01, 1'b1, 1'b0);
    do_word(8'h00, 1'b0, 1'b0);
    do_word(8'h01, 1'b1, 1'b0);
    do_word(8'h00, 1'b1, 1'b0);

    // clear_hist in IDLE without a transfer
    do_word(8'h01, 1'b1, 1'b0);
    @(negedge clk);
    clear_hist = 1'b1;
    @(negedge clk);
    clear_hist = 1'b0;
    mf = 0;
    do_word(8'h00, 1'b0, 1'b0);

    do_word(8'b1001_0010, 1'b1, 1'b1);

    // reset while bit 4 is being shifted
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = 8'b1001_0010;
    clear_hist = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    clear_hist = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_ready", in_ready, 1);
    chk("mid_valid", out_valid, 0);
    chk("mid_count", out_count, 0);
    chk("mid_h100", out_hit100, 0);
    chk("mid_h010", out_hit010, 0);
    chk("mid_busy", busy, 0);
    mh = '0;
    mf = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_novalid", out_valid, 0);
    do_word(8'b1001_0010, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++)
      do_word(W'($urandom), 1'($urandom_range(1)), 1'b0);

    chk("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
